// File: rtl/ln_horner_core.sv
`default_nettype none
// ============================================================================
// Module   : ln_horner_core
// Purpose  : Iterative float32 evaluator of the truncated series
//            ln(1+x) = sum_{k=1..N} (-1)^(k+1) x^k / k in Horner form,
//            sharing one pipelined multiplier and one pipelined adder.
//            Zero and out-of-domain operands finish through a fast path.
// Options  : LN_RUNTIME_TERMS_EN adds the n_terms input; the effective term
//            count is clamp(n_terms, 2, TERMS), sampled with x on accept.
// Revision : 1.0 - initial release
// ============================================================================
module ln_horner_core #(
  parameter int TERMS   = 5,
  parameter int MUL_LAT = 11,
  parameter int ADD_LAT = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x,
  input  logic        start,
`ifdef LN_RUNTIME_TERMS_EN
  input  logic [3:0]  n_terms,
`endif
  output logic        ready,
  output logic [31:0] ln,
  output logic        done,
  output logic        error
);

  localparam int CNT_W = $clog2(((MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT) + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] ADD_LAST = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       TERMS_4  = 4'(TERMS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD  = 3'd2,
    S_FMUL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Series coefficients 1/k, sign set for even k.
  function automatic logic [31:0] coef(input logic [3:0] idx);
    case (idx)
      4'd1:    coef = 32'h3F800000;
      4'd2:    coef = 32'hBF000000;
      4'd3:    coef = 32'h3EAAAAAB;
      4'd4:    coef = 32'hBE800000;
      4'd5:    coef = 32'h3E4CCCCD;
      4'd6:    coef = 32'hBE2AAAAB;
      4'd7:    coef = 32'h3E124925;
      4'd8:    coef = 32'hBE000000;
      default: coef = 32'h00000000;
    endcase
  endfunction

  // Float32 multiply, round-to-nearest-even; subnormals flush to zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        p;
    logic [23:0]        m;
    logic               g;
    logic               st;
    logic [24:0]        mr;
    logic signed [10:0] e;
    s = a[31] ^ b[31];
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 11'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, (g & (st | m[0]))};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 11'sd1;
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 11'sd0 || !mr[23])
      fmul = {s, 31'd0};
    else if (e >= 11'sd255)
      fmul = {s, 8'hFF, 23'd0};
    else
      fmul = {s, e[7:0], mr[22:0]};
  endfunction

  // Float32 add, round-to-nearest-even with guard/round/sticky bits.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        big;
    logic [31:0]        sml;
    logic [26:0]        mb;
    logic [26:0]        ms;
    logic [26:0]        msh;
    logic [27:0]        sum;
    logic [7:0]         d;
    logic               sticky;
    logic [4:0]         lz;
    logic               found;
    logic [24:0]        mr;
    logic signed [10:0] e;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    mb     = {1'b1, big[22:0], 3'b000};
    ms     = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    d      = big[30:23] - sml[30:23];
    sticky = 1'b0;
    if (d >= 8'd27) begin
      msh = {26'd0, |ms};
    end else begin
      msh    = ms >> d;
      sticky = |(ms & ((27'd1 << d) - 27'd1));
      msh[0] = msh[0] | sticky;
    end
    e = $signed({3'b000, big[30:23]});
    if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, msh};
    else                    sum = {1'b0, mb} - {1'b0, msh};
    lz    = 5'd0;
    found = 1'b0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 11'sd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (sum[i]) found = 1'b1;
          else        lz    = lz + 5'd1;
        end
      end
      sum = sum << lz;
      e   = e - $signed({6'd0, lz});
    end
    mr = {1'b0, sum[26:3]} + {24'd0, (sum[2] & (sum[1] | sum[0] | sum[3]))};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 11'sd1;
    end
    if (big[30:23] == 8'd0 || e <= 11'sd0 || !mr[23])
      fadd = 32'd0;
    else if (e >= 11'sd255)
      fadd = {big[31], 8'hFF, 23'd0};
    else
      fadd = {big[31], e[7:0], mr[22:0]};
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       k;
  logic [31:0]      xr;
  logic [31:0]      mul_a;     // doubles as the Horner accumulator
  logic [31:0]      mul_b;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      prod;
  logic [31:0]      sum;
  logic [31:0]      mul_pipe [MUL_LAT-1];
  logic [31:0]      add_pipe [ADD_LAT-1];
  logic [3:0]       n_in;
  logic             x_err;
  logic             x_zero;
  logic             accept;
  logic             mul_end;
  logic             add_end;
  logic             fmul_end;

`ifdef LN_RUNTIME_TERMS_EN
  assign n_in = (n_terms < 4'd2) ? 4'd2 : ((n_terms > TERMS_4) ? TERMS_4 : n_terms);
`else
  assign n_in = TERMS_4;
`endif

  assign x_err  = ({1'b0, x[30:0]} > 32'h3F800000) || (x == 32'hBF800000);
  assign x_zero = (x[30:0] == 31'd0);

  // Shared multiplier: result usable MUL_LAT edges after operands register.
  always_ff @(posedge clk) begin
    mul_pipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign prod = mul_pipe[MUL_LAT-2];

  // Shared adder: result usable ADD_LAT edges after operands register.
  always_ff @(posedge clk) begin
    add_pipe[0] <= fadd(add_a, add_b);
    for (int i = 1; i < ADD_LAT - 1; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign sum = add_pipe[ADD_LAT-2];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode, handshake outputs and phase-end strobes.
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    mul_end  = 1'b0;
    add_end  = 1'b0;
    fmul_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = (x_err || x_zero) ? S_DONE : S_MUL;
        end
      end
      S_MUL: begin
        if (cnt == MUL_LAST) begin
          mul_end = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (cnt == ADD_LAST) begin
          add_end = 1'b1;
          state_d = (k == 4'd1) ? S_FMUL : S_MUL;
        end
      end
      S_FMUL: begin
        if (cnt == MUL_LAST) begin
          fmul_end = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand registers are written only at phase boundaries so the
  // shared units see stable inputs for the whole wait window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ln    <= 32'd0;
      error <= 1'b0;
      cnt   <= '0;
      k     <= 4'd0;
      xr    <= 32'd0;
      mul_a <= 32'd0;
      mul_b <= 32'd0;
      add_a <= 32'd0;
      add_b <= 32'd0;
    end else begin
      cnt <= cnt + CNT_ONE;
      if (accept) begin
        xr    <= x;
        k     <= n_in - 4'd1;
        mul_a <= coef(n_in);
        mul_b <= x;
        cnt   <= '0;
        if (x_err || x_zero) begin
          ln    <= 32'd0;
          error <= x_err;
        end
      end
      if (mul_end) begin
        add_a <= prod;
        add_b <= coef(k);
        cnt   <= '0;
      end
      if (add_end) begin
        mul_a <= sum;
        mul_b <= xr;
        k     <= k - 4'd1;
        cnt   <= '0;
      end
      if (fmul_end) begin
        ln    <= prod;
        error <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ln_horner_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_ln_horner_core
// Purpose  : Self-checking bench for ln_horner_core against a real-valued
//            series model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ln_horner_core;

  localparam int TERMS = 5;

  logic        clk;
  logic        rst_n;
  logic [31:0] x;
  logic        start;
  logic [3:0]  n_terms;
  logic        ready;
  logic [31:0] ln;
  logic        done;
  logic        error;

  int total;
  int bad;
  int dcyc[$];
  logic [31:0] dln[$];
  int aborted_dones;
  int d0;
  int d1;
  logic [31:0] l0;
  logic [31:0] l1;
  int nt_r;
  logic [31:0] xr_r;

  ln_horner_core #(.TERMS(TERMS), .MUL_LAT(11), .ADD_LAT(14)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (x),
    .start   (start),
`ifdef LN_RUNTIME_TERMS_EN
    .n_terms (n_terms),
`endif
    .ready   (ready),
    .ln      (ln),
    .done    (done),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic real ref_ln(input real xv, input int n);
    real s;
    real p;
    s = 0.0;
    p = 1.0;
    for (int kk = 1; kk <= n; kk++) begin
      p = p * xv;
      if (kk % 2 == 1) s = s + p / kk;
      else             s = s - p / kk;
    end
    return s;
  endfunction

  function automatic logic [31:0] dbl2flt(input real r);
    logic [63:0] d;
    logic [23:0] m;
    logic        up;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e  = int'({21'd0, d[62:52]}) - 896;
    up = d[28] & ((|d[27:0]) | d[29]);
    m  = {1'b0, d[51:29]} + {23'd0, up};
    if (m[23]) e = e + 1;
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic real flt2dbl(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic int ulp_diff(input logic [31:0] a, input logic [31:0] b);
    int da;
    int db;
    if (a[31] != b[31]) return ((a[30:0] | b[30:0]) == 31'd0) ? 0 : 32'h7fffffff;
    da = int'({1'b0, a[30:0]});
    db = int'({1'b0, b[30:0]});
    return (da > db) ? da - db : db - da;
  endfunction

  function automatic int eff_n(input logic [3:0] nt);
`ifdef LN_RUNTIME_TERMS_EN
    if (nt < 4'd2) return 2;
    if (int'(nt) > TERMS) return TERMS;
    return int'(nt);
`else
    return TERMS;
`endif
  endfunction

  function automatic int lat_of(input int n);
    return (n - 1) * 25 + 11 + 1;
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                         input int tol);
    total++;
    assert ((ulp_diff(obs, exp) <= tol) === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (tol %0d ulp)", tag, obs, exp, tol);
    end
  endtask

  // One transaction: accept at cycle 0, watch done/ready/ln up to lat+4.
  task automatic run_op(input string tag, input logic [31:0] xin, input logic [3:0] nt,
                        input logic [31:0] exp_ln, input int tol, input logic exp_err,
                        input int exp_lat);
    int          done_cyc;
    int          done_cnt;
    logic        rdy_ok;
    logic [31:0] ln_at;
    logic        err_at;
    @(negedge clk);
    chk({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
    x        = xin;
    n_terms  = nt;
    start    = 1'b1;
    done_cyc = -1;
    done_cnt = 0;
    rdy_ok   = 1'b1;
    ln_at    = 32'hDEADBEEF;
    err_at   = 1'bx;
    for (int c = 1; c <= exp_lat + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start   = 1'b0;
        x       = $urandom;
        n_terms = 4'($urandom);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          ln_at    = ln;
          err_at   = error;
        end
      end
      if (c <= exp_lat && ready !== 1'b0) rdy_ok = 1'b0;
      if (c == exp_lat + 1) chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_lat));
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_ready_busy"}, {31'd0, rdy_ok}, 32'd1);
    chk({tag, "_error"}, {31'd0, err_at}, {31'd0, exp_err});
    chk_ulp({tag, "_ln"}, ln_at, exp_ln, tol);
    chk({tag, "_ln_held"}, ln, ln_at);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    x       = 32'd0;
    n_terms = 4'd5;

    repeat (3) @(negedge clk);
    chk("rst_ln", ln, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b1;

    // Normal operands.
    run_op("half", 32'h3F000000, 4'd5, 32'h3ED08888, 2, 1'b0, 112);
    run_op("quarter", 32'h3E800000, 4'd5, dbl2flt(ref_ln(0.25, 5)), 2, 1'b0, 112);

    // Fast paths.
    run_op("zero_p", 32'h00000000, 4'd5, 32'd0, 0, 1'b0, 1);
    run_op("zero_n", 32'h80000000, 4'd5, 32'd0, 0, 1'b0, 1);
    run_op("err_big", 32'h3FC00000, 4'd5, 32'd0, 0, 1'b1, 1);
    run_op("err_m1", 32'hBF800000, 4'd5, 32'd0, 0, 1'b1, 1);
    run_op("err_inf", 32'h7F800000, 4'd5, 32'd0, 0, 1'b1, 1);
    run_op("one", 32'h3F800000, 4'd5, dbl2flt(ref_ln(1.0, 5)), 2, 1'b0, 112);

    // Ignored starts while busy and in the done cycle; accept right after.
    @(negedge clk);
    x       = 32'h3F000000;
    n_terms = 4'd5;
    start   = 1'b1;
    for (int c = 1; c <= 232; c++) begin
      @(negedge clk);
      x     = 32'h3E800000;
      start = (c == 5 || c == 112 || c == 113) ? 1'b1 : 1'b0;
      if (done === 1'b1) begin
        dcyc.push_back(c);
        dln.push_back(ln);
      end
    end
    start = 1'b0;
    d0 = (dcyc.size() > 0) ? dcyc[0] : -1;
    d1 = (dcyc.size() > 1) ? dcyc[1] : -1;
    l0 = (dln.size() > 0) ? dln[0] : 32'hDEADBEEF;
    l1 = (dln.size() > 1) ? dln[1] : 32'hDEADBEEF;
    chk("b2b_done_count", 32'(dcyc.size()), 32'd2);
    chk("b2b_first_cycle", 32'(d0), 32'd112);
    chk_ulp("b2b_first_ln", l0, 32'h3ED08888, 2);
    chk("b2b_second_cycle", 32'(d1), 32'd225);
    chk_ulp("b2b_second_ln", l1, dbl2flt(ref_ln(0.25, 5)), 2);

    // Reset in the middle of an operation.
    @(negedge clk);
    x       = 32'h3F000000;
    n_terms = 4'd5;
    start   = 1'b1;
    aborted_dones = 0;
    for (int c = 1; c <= 170; c++) begin
      @(negedge clk);
      if (c == 1)  start = 1'b0;
      if (c == 50) rst_n = 1'b0;
      if (c == 53) rst_n = 1'b1;
      if (done === 1'b1) aborted_dones++;
      if (c == 51) begin
        chk("abort_ln", ln, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_error", {31'd0, error}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
      end
    end
    chk("abort_no_done", 32'(aborted_dones), 32'd0);
    run_op("after_rst", 32'h3E800000, 4'd5, dbl2flt(ref_ln(0.25, 5)), 2, 1'b0, 112);

`ifdef LN_RUNTIME_TERMS_EN
    run_op("nt2", 32'h3F000000, 4'd2, 32'h3EC00000, 0, 1'b0, 37);
    run_op("nt0", 32'h3F000000, 4'd0, 32'h3EC00000, 0, 1'b0, 37);
    run_op("nt15", 32'h3F000000, 4'd15, 32'h3ED08888, 2, 1'b0, 112);
    run_op("nt3", 32'h3E800000, 4'd3, dbl2flt(ref_ln(0.25, 3)), 2, 1'b0, lat_of(3));
`endif

    // Randomized operands in (-0.99, 0.99) excluding tiny magnitudes.
    for (int i = 0; i < 8; i++) begin
      real r;
      r = (real'($urandom_range(0, 19800)) - 9900.0) / 10000.0;
      if (r < 0.01 && r > -0.01) r = 0.3;
      xr_r = dbl2flt(r);
      nt_r = int'($urandom_range(0, 15));
      run_op($sformatf("rand%0d", i), xr_r, 4'(nt_r),
             dbl2flt(ref_ln(flt2dbl(xr_r), eff_n(4'(nt_r)))), 3, 1'b0,
             lat_of(eff_n(4'(nt_r))));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
